// File: rtl/lms_ctr_mem_boot_loader.sv
// Boot loader: packs a flash byte stream into 32-bit little-endian words and
// writes them to on-chip memory, holding the CPU in reset until the image is in.
module lms_ctr_mem_boot_loader #(
  parameter int ADDR_W    = 14,
  parameter int NUM_WORDS = 12288
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic [7:0]        src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_reset_req,
  output logic [31:0]       checksum
);

  // state   | meaning
  // S_IDLE  | waiting for start after reset
  // S_FILL  | accepting bytes, assembling the current word
  // S_WRITE | one-cycle memory write of the assembled word
  // S_DONE  | image loaded, CPU released
  // S_ERR   | last start had an out-of-range length
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(NUM_WORDS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   word_addr_q, word_addr_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         data_q, data_d;
  logic [31:0]         checksum_q, checksum_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                len_ok;

  assign len_ok = (len_words != '0) && (len_words <= MAX_LEN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      word_addr_q <= '0;
      byte_cnt_q  <= '0;
      data_q      <= '0;
      checksum_q  <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      byte_cnt_q  <= byte_cnt_d;
      data_q      <= data_d;
      checksum_q  <= checksum_d;
      len_q       <= len_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    word_addr_d   = word_addr_q;
    byte_cnt_d    = byte_cnt_q;
    data_d        = data_q;
    checksum_d    = checksum_q;
    len_d         = len_q;
    src_ready     = 1'b0;
    mem_write     = 1'b0;
    mem_chipselect = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    cpu_reset_req = 1'b1;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        done          = (state_q == S_DONE);
        error         = (state_q == S_ERR);
        cpu_reset_req = (state_q != S_DONE);
        if (start) begin
          if (len_ok) begin
            word_addr_d = '0;
            byte_cnt_d  = '0;
            data_d      = '0;
            checksum_d  = '0;
            len_d       = len_words;
            state_d     = S_FILL;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_FILL: begin
        busy      = 1'b1;
        src_ready = 1'b1;
        if (src_valid) begin
          data_d[{byte_cnt_q, 3'b000} +: 8] = src_data;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        busy           = 1'b1;
        mem_write      = 1'b1;
        mem_chipselect = 1'b1;
        checksum_d     = checksum_q + data_q;
        if ({1'b0, word_addr_q} == len_q - 1'b1) begin
          state_d = S_DONE;
        end else begin
          word_addr_d = word_addr_q + 1'b1;
          state_d     = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_address    = word_addr_q;
  assign mem_writedata  = data_q;
  assign mem_byteenable = 4'hF;
  assign checksum       = checksum_q;

endmodule
